// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per clock; busy stalls the pipeline until done pulses.
// Optional build macro SEQ_DIVIDER_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow skip the iteration loop and go straight to sign fix-up.
module seq_divider #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t state, state_nxt;

   // Datapath registers
   logic [XLEN-1:0]  rem;      // partial remainder (always < divisor magnitude)
   logic [XLEN-1:0]  quo;      // dividend shifting out / quotient shifting in
   logic [XLEN-1:0]  dvs;      // divisor magnitude
   logic [CNT_W-1:0] cnt;
   logic             sel_rem;  // op[1]: return remainder instead of quotient
   logic             neg_q;
   logic             neg_r;

   // FSM-derived controls
   logic accept;
   logic iterate;
   logic finish;

   // Operand conditioning at accept
   logic            signed_op;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;

   // One iteration: shift, then trial subtract at XLEN+1 bits
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   trial;
   logic            trial_ok;
   logic            cnt_last;

   // Sign fix-up
   logic [XLEN-1:0] q_fin;
   logic [XLEN-1:0] r_fin;

   assign signed_op = ~op[0];
   assign a_neg     = signed_op & a[XLEN-1];
   assign b_neg     = signed_op & b[XLEN-1];
   // |0x80000000| is 0x80000000 as an unsigned XLEN-bit magnitude
   assign a_mag     = a_neg ? (~a + XLEN'(1)) : a;
   assign b_mag     = b_neg ? (~b + XLEN'(1)) : b;

   // rem_sh < 2*dvs, so the difference always fits in XLEN+1 signed bits;
   // subtraction is add of the inverted divisor with carry-in 1
   assign rem_sh    = {rem, quo[XLEN-1]};
   assign trial     = rem_sh + {1'b1, ~dvs} + (XLEN+1)'(1);
   assign trial_ok  = ~trial[XLEN];
   assign cnt_last  = (cnt == CNT_W'(XLEN-1));

`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
   logic b_zero;
   logic ovf;
   logic special;
   assign b_zero  = (b == '0);
   assign ovf     = signed_op & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
   assign special = b_zero | ovf;
`endif

   // Divide by zero forces an all-ones quotient; the remainder naturally
   // comes out as |a| re-signed, i.e. a. Signed overflow needs no forcing:
   // 0x80000000 negated wraps to itself and the remainder is 0.
   always_comb begin
      q_fin = neg_q ? (~quo + XLEN'(1)) : quo;
      if (dvs == '0)
         q_fin = '1;
      r_fin = neg_r ? (~rem + XLEN'(1)) : rem;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
               state_nxt = special ? FIX : CALC;
`else
               state_nxt = CALC;
`endif
            end
         end
         CALC:    if (cnt_last) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs; busy drops in the done cycle since FIX returns to IDLE
   always_comb begin
      busy    = (state != IDLE);
      accept  = (state == IDLE) & start;
      iterate = (state == CALC);
      finish  = (state == FIX);
   end

   // Operand latch, iteration datapath and counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         cnt     <= '0;
         sel_rem <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else if (accept) begin
         rem     <= '0;
         quo     <= a_mag;
         dvs     <= b_mag;
         cnt     <= '0;
         sel_rem <= op[1];
         neg_q   <= a_neg ^ b_neg;
         neg_r   <= a_neg;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
         // Preload what the loop would have produced: for b=0 the remainder
         // is |a| and the quotient is forced in FIX; for overflow quo already
         // holds 0x80000000 and must not be negated.
         if (special)
            neg_q <= 1'b0;
         if (b_zero)
            rem <= a_mag;
`endif
      end else if (iterate) begin
         rem <= trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
         quo <= {quo[XLEN-2:0], trial_ok};
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Result capture and one-cycle done pulse; result holds until next FIX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= finish;
         if (finish)
            result <= sel_rem ? r_fin : q_fin;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with an expected-result scoreboard.
module tb_seq_divider;

   localparam int XLEN = 32;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
   localparam int LAT_SPECIAL = 1;
`else
   localparam int LAT_SPECIAL = 33;
`endif
   localparam int LAT = 33;

   logic            clk;
   logic            rst;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] result;
   logic            busy;
   logic            done;

   int checks = 0;
   int errors = 0;
   logic [XLEN-1:0] sb[$];

   seq_divider #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .result(result), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; drives start through one accept edge.
   task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic [XLEN-1:0] e, input bit push);
      op = o; a = x; b = y; start = 1'b1;
      if (push) sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h0000_0003;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   // Counts edges after the accept edge until done; optional junk start pulses.
   task automatic wait_done(input string tag, input int exp_lat, input int p1, input int p2);
      int lat;
      logic [XLEN-1:0] e;
      lat = 0;
      while (!done && lat < 200) begin
         if (lat == p1 || lat == p2) begin
            start = 1'b1; op = 2'b01; a = 32'h0000_FFFF; b = 32'h0000_0001;
         end else
            start = 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_result"}, result, e);
      end else
         check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #12;
      check("reset_result", result, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Unsigned basics
      issue(2'b01, 32'd100, 32'd7, 32'd14, 1);        wait_done("divu_100_7", LAT, -1, -1);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      issue(2'b11, 32'd100, 32'd7, 32'd2, 1);         wait_done("remu_100_7", LAT, -1, -1);
      issue(2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1); wait_done("divu_big", LAT, -1, -1);
      issue(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 1);  wait_done("remu_big", LAT, -1, -1);

      // Signed
      issue(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1); wait_done("div_neg100_7", LAT, -1, -1);
      issue(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1); wait_done("rem_neg100_7", LAT, -1, -1);
      issue(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1); wait_done("div_7_neg2", LAT, -1, -1);
      issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1);         wait_done("rem_7_neg2", LAT, -1, -1);

      // Divide by zero
      issue(2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1); wait_done("div_by0", LAT_SPECIAL, -1, -1);
      issue(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 1); wait_done("rem_by0", LAT_SPECIAL, -1, -1);
      issue(2'b00, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 1); wait_done("div_neg_by0", LAT_SPECIAL, -1, -1);
      issue(2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 1); wait_done("rem_neg_by0", LAT_SPECIAL, -1, -1);
      issue(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1); wait_done("divu_by0", LAT_SPECIAL, -1, -1);

      // Signed overflow
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); wait_done("div_ovf", LAT_SPECIAL, -1, -1);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);         wait_done("rem_ovf", LAT_SPECIAL, -1, -1);
      issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);         wait_done("divu_ovf_ops", LAT, -1, -1);

      // start while busy ignored; start in done cycle accepted
      issue(2'b01, 32'd1000, 32'd9, 32'd111, 1);
      wait_done("ignore_start", LAT, 4, 19);
      issue(2'b11, 32'd1000, 32'd9, 32'd1, 1);        // in the done cycle
      wait_done("back_to_back", LAT, -1, -1);

      // Asynchronous reset mid-operation
      issue(2'b01, 32'd5000, 32'd7, 32'd0, 0);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      check("rst_mid_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_no_done", {31'd0, done}, 32'd0);
      issue(2'b01, 32'd5000, 32'd7, 32'd714, 1);      wait_done("after_rst", LAT, -1, -1);

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
